// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_CH_DEF = 8;
  localparam int SEL_W_DEF  = 3;
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan request, mux select/sample and captured-word handshake bundle.
interface mux_scan_sequencer_if #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
);
  logic              start;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic [NUM_CH-1:0] data;
  logic              data_valid;
  logic              out_ready;

  modport master (
    input  start, mux_out, out_ready,
    output sel, busy, data, data_valid
  );

  modport slave (
    output start, mux_out, out_ready,
    input  sel, busy, data, data_valid
  );
endinterface

// File: rtl/Mux_8_to_1.sv
// Combinational 8:1 select mux whose output the sequencer scans.
module Mux_8_to_1 (
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       H,
  input  logic [2:0] S,
  output logic       M
);
  always_comb begin
    M = A;
    case (S)
      3'd0: M = A;
      3'd1: M = B;
      3'd2: M = C;
      3'd3: M = D;
      3'd4: M = E;
      3'd5: M = F;
      3'd6: M = G;
      3'd7: M = H;
      default: M = A;
    endcase
  end
endmodule

// File: rtl/mux_settle_counter.sv
// Loadable down-counter with zero flag; load wins over decrement.
module mux_settle_counter
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero_o = (value_q == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through every channel, waits SETTLE cycles on each,
// samples the mux output and presents the assembled word with valid/ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mux_scan_sequencer_if.master  bus
);
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  mux_settle_counter u_settle (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(SETTLE)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SCAN;
          sel_d    = '0;
          data_d   = '0;
          cnt_load = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) data_d[i] = bus.mux_out;
          end
          // Last channel: sel parks at NUM_CH-1, no wrap.
          if (sel_q == SEL_W'(NUM_CH - 1)) begin
            state_d = ST_DONE;
          end else begin
            sel_d    = sel_q + SEL_W'(1);
            cnt_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.data       = data_q;
  assign bus.busy       = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign bus.data_valid = (state_q == ST_DONE);
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two sequencers (SETTLE=2 and SETTLE=0) each scanning a real 8:1 mux.
module tb_mux_scan_sequencer;
  logic       clk;
  logic       reset_n;
  logic [7:0] ch_in;
  int         checks;
  int         failures;

  mux_scan_sequencer_if #(.NUM_CH(8), .SEL_W(3)) bus0 ();
  mux_scan_sequencer_if #(.NUM_CH(8), .SEL_W(3)) bus1 ();

  mux_scan_sequencer #(.NUM_CH(8), .SEL_W(3), .SETTLE(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  mux_scan_sequencer #(.NUM_CH(8), .SEL_W(3), .SETTLE(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  Mux_8_to_1 u_mux0 (
    .A(ch_in[0]), .B(ch_in[1]), .C(ch_in[2]), .D(ch_in[3]),
    .E(ch_in[4]), .F(ch_in[5]), .G(ch_in[6]), .H(ch_in[7]),
    .S(bus0.sel), .M(bus0.mux_out)
  );
  Mux_8_to_1 u_mux1 (
    .A(ch_in[0]), .B(ch_in[1]), .C(ch_in[2]), .D(ch_in[3]),
    .E(ch_in[4]), .F(ch_in[5]), .G(ch_in[6]), .H(ch_in[7]),
    .S(bus1.sel), .M(bus1.mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on dut0 and counts edges from the edge preceding the pulse
  // until data_valid shows; optionally re-pulses start mid-scan.
  task automatic run_scan(input string tag, input bit extra_starts, output int lat);
    int n;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    n = 1;
    while (!bus0.data_valid && n < 200) begin
      check({tag, "_busy"}, 32'(bus0.busy), 32'd1);
      bus0.start = (extra_starts && (n == 3 || n == 10)) ? 1'b1 : 1'b0;
      step();
      n++;
    end
    bus0.start = 1'b0;
    lat = n;
    $display("scan %s: latency=%0d data=%02h", tag, lat, bus0.data);
  endtask

  task automatic accept0(input string tag, input bit with_start);
    bus0.out_ready = 1'b1;
    bus0.start     = with_start;
    step();
    bus0.out_ready = 1'b0;
    bus0.start     = 1'b0;
    check({tag, "_valid_after_acc"}, 32'(bus0.data_valid), 32'd0);
    check({tag, "_busy_after_acc"}, 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    checks         = 0;
    failures       = 0;
    ch_in          = 8'h00;
    bus0.start     = 1'b0;
    bus0.out_ready = 1'b0;
    bus1.start     = 1'b0;
    bus1.out_ready = 1'b0;
    reset_n        = 1'b1;
    #2 reset_n     = 1'b0;
    repeat (3) step();

    check("rst_sel", 32'(bus0.sel), 32'd0);
    check("rst_data", 32'(bus0.data), 32'd0);
    check("rst_valid", 32'(bus0.data_valid), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_busy", 32'(bus0.busy), 32'd0);

    // Basic scan: A..H = 1,0,1,1,0,0,1,0 -> 8'b0100_1101
    ch_in = 8'h4D;
    run_scan("basic", 1'b0, lat);
    check("basic_lat", 32'(lat), 32'd25);
    check("basic_data", 32'(bus0.data), 32'h4D);
    check("basic_sel", 32'(bus0.sel), 32'd7);
    check("basic_busy", 32'(bus0.busy), 32'd1);
    accept0("basic", 1'b0);
    check("basic_data_kept", 32'(bus0.data), 32'h4D);

    // SETTLE=0: sel advances every cycle, valid 9 edges after start edge
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s0_sel%0d", k), 32'(bus1.sel), 32'(k));
      check($sformatf("s0_novalid%0d", k), 32'(bus1.data_valid), 32'd0);
      step();
    end
    check("s0_valid", 32'(bus1.data_valid), 32'd1);
    check("s0_data", 32'(bus1.data), 32'h4D);
    $display("scan s0: data=%02h valid=%0b", bus1.data, bus1.data_valid);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("s0_valid_after_acc", 32'(bus1.data_valid), 32'd0);

    // Backpressure: inputs change while the word is held
    ch_in = 8'h4D;
    run_scan("bp", 1'b0, lat);
    check("bp_lat", 32'(lat), 32'd25);
    ch_in = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("bp_data%0d", k), 32'(bus0.data), 32'h4D);
      check($sformatf("bp_valid%0d", k), 32'(bus0.data_valid), 32'd1);
      check($sformatf("bp_sel%0d", k), 32'(bus0.sel), 32'd7);
    end
    accept0("bp", 1'b0);

    // Ignored starts during SCAN and on the accept cycle
    ch_in = 8'h96;
    run_scan("ign", 1'b1, lat);
    check("ign_lat", 32'(lat), 32'd25);
    check("ign_data", 32'(bus0.data), 32'h96);
    accept0("ign", 1'b1);
    for (int k = 0; k < 30; k++) begin
      step();
      check($sformatf("ign_idle_busy%0d", k), 32'(bus0.busy), 32'd0);
      check($sformatf("ign_idle_valid%0d", k), 32'(bus0.data_valid), 32'd0);
    end

    // Reset mid-scan while sel==4, checked before any clock edge
    ch_in = 8'h4D;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    n = 0;
    while (bus0.sel != 3'd4 && n < 100) begin
      step();
      n++;
    end
    check("mid_sel_pre", 32'(bus0.sel), 32'd4);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(bus0.sel), 32'd0);
    check("mid_rst_data", 32'(bus0.data), 32'd0);
    check("mid_rst_valid", 32'(bus0.data_valid), 32'd0);
    check("mid_rst_busy", 32'(bus0.busy), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    ch_in = 8'h5A;
    run_scan("post_rst", 1'b0, lat);
    check("post_rst_lat", 32'(lat), 32'd25);
    check("post_rst_data", 32'(bus0.data), 32'h5A);
    accept0("post_rst", 1'b0);

    // Back-to-back: start in the first IDLE cycle after each accept
    ch_in = 8'hA5;
    run_scan("b2b_a", 1'b0, lat);
    check("b2b_a_lat", 32'(lat), 32'd25);
    check("b2b_a_data", 32'(bus0.data), 32'hA5);
    accept0("b2b_a", 1'b0);
    ch_in = 8'h3C;
    run_scan("b2b_b", 1'b0, lat);
    check("b2b_b_lat", 32'(lat), 32'd25);
    check("b2b_b_data", 32'(bus0.data), 32'h3C);
    accept0("b2b_b", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
